// File: rtl/alu_md_if.sv
// EX-stage ALU / multiply-divide bus: operands and opcodes in, results and HI/LO/Busy out.
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [SHW-1:0]   Shamt;
  logic [3:0]       ALU_Ctr;
  logic             Start;
  logic [2:0]       MD_Op;
  logic [WIDTH-1:0] ALU_Result;
  logic             Zero;
  logic             Overflow;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;

  modport master (
    output SrcA, SrcB, Shamt, ALU_Ctr, Start, MD_Op,
    input  ALU_Result, Zero, Overflow, HI, LO, Busy
  );

  modport slave (
    input  SrcA, SrcB, Shamt, ALU_Ctr, Start, MD_Op,
    output ALU_Result, Zero, Overflow, HI, LO, Busy
  );
endinterface

// File: rtl/alu_md.sv
// Combinational ALU plus an iterative radix-2 multiply/divide unit that owns HI/LO.
module alu_md #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  alu_md_if.slave   bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [SHW:0] CntInit = (SHW + 1)'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} md_state_e;

  // ---------------- ALU ----------------
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             ovf;

  always_comb begin
    sum     = bus.SrcA + bus.SrcB;
    diff    = bus.SrcA - bus.SrcB;
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.ALU_Ctr)
      4'd0: begin
        alu_res = sum;
        ovf     = (bus.SrcA[MSB] == bus.SrcB[MSB]) && (sum[MSB] != bus.SrcA[MSB]);
      end
      4'd1: begin
        alu_res = diff;
        ovf     = (bus.SrcA[MSB] != bus.SrcB[MSB]) && (diff[MSB] != bus.SrcA[MSB]);
      end
      4'd2:  alu_res = bus.SrcA | bus.SrcB;
      4'd3:  alu_res = bus.SrcB << (WIDTH / 2);
      4'd4:  alu_res = bus.SrcA & bus.SrcB;
      4'd5:  alu_res = bus.SrcA ^ bus.SrcB;
      4'd6:  alu_res = ~(bus.SrcA | bus.SrcB);
      4'd7:  alu_res = {{(WIDTH - 1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      4'd8:  alu_res = {{(WIDTH - 1){1'b0}}, bus.SrcA < bus.SrcB};
      4'd9:  alu_res = bus.SrcB << bus.Shamt;
      4'd10: alu_res = bus.SrcB >> bus.Shamt;
      4'd11: alu_res = $unsigned($signed(bus.SrcB) >>> bus.Shamt);
      4'd12: alu_res = bus.SrcB << bus.SrcA[SHW-1:0];
      4'd13: alu_res = bus.HI;
      4'd14: alu_res = bus.LO;
      default: alu_res = '0;
    endcase
  end

  assign bus.ALU_Result = alu_res;
  assign bus.Zero       = (alu_res == '0);
  assign bus.Overflow   = ovf;

  // ---------------- Multiply / divide ----------------
  md_state_e          state_q;
  logic [SHW:0]       cnt_q;
  logic               is_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   mcand_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;

  logic               signed_op, a_neg, b_neg, md_neg_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    signed_op = ~bus.MD_Op[0];
    a_neg     = signed_op & bus.SrcA[MSB];
    b_neg     = signed_op & bus.SrcB[MSB];
    a_mag     = a_neg ? -bus.SrcA : bus.SrcA;
    b_mag     = b_neg ? -bus.SrcB : bus.SrcB;
    // Divide by zero keeps an all-ones quotient regardless of dividend sign.
    md_neg_lo = (a_neg ^ b_neg) & ~(bus.MD_Op[1] & (bus.SrcB == '0));
  end

  // acc_q holds {partial product, multiplier} or {remainder, quotient/dividend}.
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod;
  logic [WIDTH-1:0]     fin_hi, fin_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q};
    rem_sub   = WIDTH'(div_shift - {1'b0, mcand_q});
    div_next  = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    step_next = is_div_q ? div_next : mul_next;
    prod      = neg_lo_q ? -step_next : step_next;
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
      fin_hi = neg_hi_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.Start) begin
            case (bus.MD_Op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                is_div_q <= bus.MD_Op[1];
                neg_lo_q <= md_neg_lo;
                neg_hi_q <= a_neg;
                mcand_q  <= b_mag;
                acc_q    <= {{WIDTH{1'b0}}, a_mag};
                cnt_q    <= CntInit;
                state_q  <= StRun;
              end
              3'd4:    hi_q <= bus.SrcA;
              3'd5:    lo_q <= bus.SrcA;
              default: ;
            endcase
          end
        end
        StRun: begin
          acc_q <= step_next;
          if (cnt_q == '0) begin
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Busy = (state_q == StRun);
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at WIDTH=32 and WIDTH=16 with hand-computed expectations.
module tb_alu_md;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc;

  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(32)) b32 ();
  alu_md_if #(.WIDTH(16)) b16 ();

  alu_md #(.WIDTH(32)) u32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  alu_md #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic alu32(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    b32.ALU_Ctr = ctr;
    b32.SrcA    = a;
    b32.SrcB    = b;
    b32.Shamt   = sh;
    #1;
  endtask

  task automatic alu16(input logic [3:0] ctr, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    b16.ALU_Ctr = ctr;
    b16.SrcA    = a;
    b16.SrcB    = b;
    b16.Shamt   = '0;
    #1;
  endtask

  // Launches an op and counts cycles with Busy=1; optionally tries a div Start mid-flight.
  task automatic md32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int inject_at, output int n);
    @(negedge clk);
    b32.MD_Op = op;
    b32.SrcA  = a;
    b32.SrcB  = b;
    b32.Start = 1'b1;
    @(posedge clk);
    #1;
    b32.Start = 1'b0;
    n = 0;
    while (b32.Busy && n < 100) begin
      if (n == inject_at) begin
        b32.Start = 1'b1;
        b32.MD_Op = 3'd2;
        b32.SrcA  = 32'd9;
        b32.SrcB  = 32'd3;
      end
      @(posedge clk);
      #1;
      b32.Start = 1'b0;
      n++;
    end
  endtask

  task automatic md16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      output int n);
    @(negedge clk);
    b16.MD_Op = op;
    b16.SrcA  = a;
    b16.SrcB  = b;
    b16.Start = 1'b1;
    @(posedge clk);
    #1;
    b16.Start = 1'b0;
    n = 0;
    while (b16.Busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    b32.SrcA    = '0;
    b32.SrcB    = '0;
    b32.Shamt   = '0;
    b32.ALU_Ctr = '0;
    b32.Start   = 1'b0;
    b32.MD_Op   = 3'd6;
    b16.SrcA    = '0;
    b16.SrcB    = '0;
    b16.Shamt   = '0;
    b16.ALU_Ctr = '0;
    b16.Start   = 1'b0;
    b16.MD_Op   = 3'd6;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(b32.HI), 64'h0);
    chk("rst_lo", 64'(b32.LO), 64'h0);
    chk("rst_busy", 64'(b32.Busy), 64'h0);
    chk("rst_busy16", 64'(b16.Busy), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU, WIDTH=32
    alu32(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk("add_res", 64'(b32.ALU_Result), 64'h8000_0000);
    chk("add_ovf", 64'(b32.Overflow), 64'h1);
    chk("add_zero", 64'(b32.Zero), 64'h0);
    alu32(4'd1, 32'd5, 32'd5, 5'd0);
    chk("sub_res", 64'(b32.ALU_Result), 64'h0);
    chk("sub_zero", 64'(b32.Zero), 64'h1);
    chk("sub_ovf", 64'(b32.Overflow), 64'h0);
    alu32(4'd1, 32'h8000_0000, 32'h1, 5'd0);
    chk("sub_ovf_res", 64'(b32.ALU_Result), 64'h7FFF_FFFF);
    chk("sub_ovf_flag", 64'(b32.Overflow), 64'h1);
    alu32(4'd3, 32'h0, 32'h1234, 5'd0);
    chk("lui", 64'(b32.ALU_Result), 64'h1234_0000);
    chk("lui_ovf", 64'(b32.Overflow), 64'h0);
    alu32(4'd11, 32'h0, 32'h8000_0000, 5'd4);
    chk("sra", 64'(b32.ALU_Result), 64'hF800_0000);
    alu32(4'd10, 32'h0, 32'h8000_0000, 5'd4);
    chk("srl", 64'(b32.ALU_Result), 64'h0800_0000);
    alu32(4'd8, 32'h1, 32'hFFFF_FFFF, 5'd0);
    chk("sltu", 64'(b32.ALU_Result), 64'h1);
    alu32(4'd7, 32'h1, 32'hFFFF_FFFF, 5'd0);
    chk("slt", 64'(b32.ALU_Result), 64'h0);
    alu32(4'd6, 32'h0, 32'h0, 5'd0);
    chk("nor", 64'(b32.ALU_Result), 64'hFFFF_FFFF);
    alu32(4'd12, 32'h24, 32'h1, 5'd0);
    chk("sllv", 64'(b32.ALU_Result), 64'h10);
    alu32(4'd15, 32'h5, 32'h7, 5'd0);
    chk("op15_zero", 64'(b32.Zero), 64'h1);

    // Multiply / divide, WIDTH=32
    md32(3'd0, 32'hFFFF_FFFD, 32'd5, -1, cyc);
    chk("mult_cyc", 64'(cyc), 64'd32);
    chk("mult_hi", 64'(b32.HI), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(b32.LO), 64'hFFFF_FFF1);
    md32(3'd1, 32'hFFFF_FFFF, 32'd2, -1, cyc);
    chk("multu_hi", 64'(b32.HI), 64'h1);
    chk("multu_lo", 64'(b32.LO), 64'hFFFF_FFFE);
    md32(3'd2, 32'hFFFF_FFF9, 32'd2, -1, cyc);
    chk("div_lo", 64'(b32.LO), 64'hFFFF_FFFD);
    chk("div_hi", 64'(b32.HI), 64'hFFFF_FFFF);
    md32(3'd3, 32'd7, 32'd0, -1, cyc);
    chk("divz_cyc", 64'(cyc), 64'd32);
    chk("divz_lo", 64'(b32.LO), 64'hFFFF_FFFF);
    chk("divz_hi", 64'(b32.HI), 64'h7);
    md32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, cyc);
    chk("divmin_lo", 64'(b32.LO), 64'h8000_0000);
    chk("divmin_hi", 64'(b32.HI), 64'h0);
    md32(3'd2, 32'd7, 32'hFFFF_FFFE, -1, cyc);
    chk("div_negb_lo", 64'(b32.LO), 64'hFFFF_FFFD);
    chk("div_negb_hi", 64'(b32.HI), 64'h1);

    // Start while busy is ignored; the next op is launched on the first Busy=0 cycle
    md32(3'd0, 32'd100, 32'hFFFF_FFFE, 5, cyc);
    chk("inj_cyc", 64'(cyc), 64'd32);
    chk("inj_hi", 64'(b32.HI), 64'hFFFF_FFFF);
    chk("inj_lo", 64'(b32.LO), 64'hFFFF_FF38);
    md32(3'd1, 32'h0001_0000, 32'h0001_0000, -1, cyc);
    chk("b2b_cyc", 64'(cyc), 64'd32);
    chk("b2b_hi", 64'(b32.HI), 64'h1);
    chk("b2b_lo", 64'(b32.LO), 64'h0);

    // mthi / mtlo
    @(negedge clk);
    b32.MD_Op = 3'd4;
    b32.SrcA  = 32'hABCD;
    b32.Start = 1'b1;
    @(posedge clk);
    #1;
    b32.Start = 1'b0;
    chk("mthi_hi", 64'(b32.HI), 64'hABCD);
    chk("mthi_busy", 64'(b32.Busy), 64'h0);
    @(negedge clk);
    b32.MD_Op = 3'd5;
    b32.SrcA  = 32'h55;
    b32.Start = 1'b1;
    @(posedge clk);
    #1;
    b32.Start = 1'b0;
    chk("mtlo_lo", 64'(b32.LO), 64'h55);
    chk("mtlo_busy", 64'(b32.Busy), 64'h0);
    chk("mtlo_hi_kept", 64'(b32.HI), 64'hABCD);
    alu32(4'd13, 32'h0, 32'h0, 5'd0);
    chk("mfhi", 64'(b32.ALU_Result), 64'hABCD);

    // Reset in the middle of a multiply
    @(negedge clk);
    b32.MD_Op = 3'd0;
    b32.SrcA  = 32'h1234;
    b32.SrcB  = 32'h10;
    b32.Start = 1'b1;
    @(posedge clk);
    #1;
    b32.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 64'(b32.Busy), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(b32.Busy), 64'h0);
    chk("arst_hi", 64'(b32.HI), 64'h0);
    chk("arst_lo", 64'(b32.LO), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    md32(3'd0, 32'd6, 32'd7, -1, cyc);
    chk("post_rst_cyc", 64'(cyc), 64'd32);
    chk("post_rst_hi", 64'(b32.HI), 64'h0);
    chk("post_rst_lo", 64'(b32.LO), 64'd42);

    // WIDTH=16
    md16(3'd0, 16'hFFFF, 16'hFFFF, cyc);
    chk("w16_cyc", 64'(cyc), 64'd16);
    chk("w16_hi", 64'(b16.HI), 64'h0);
    chk("w16_lo", 64'(b16.LO), 64'h1);
    alu16(4'd3, 16'h0, 16'h12);
    chk("w16_lui", 64'(b16.ALU_Result), 64'h1200);
    alu16(4'd0, 16'h7FFF, 16'h1);
    chk("w16_add", 64'(b16.ALU_Result), 64'h8000);
    chk("w16_ovf", 64'(b16.Overflow), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised successor to the datapath ALU: a WIDTH-bit combinational ALU with an extended opcode set, plus a multi-cycle multiply/divide unit that owns the HI/LO registers. It sits in the EX stage. ALU ops complete in the same cycle. MULT/DIV ops run iteratively under a Start/Busy handshake, and the hazard unit stalls on Busy.

## Interface
Parameters:
- WIDTH, 32, datapath width; even, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- SrcA  in  WIDTH  operand A
- SrcB  in  WIDTH  operand B
- Shamt  in  SHW  immediate shift amount
- ALU_Ctr  in  4  ALU opcode
- Start  in  1  launch MD_Op; sampled on a clk edge
- MD_Op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 no-op
- ALU_Result  out  WIDTH  combinational result
- Zero  out  1  ALU_Result == 0
- Overflow  out  1  signed overflow of add/sub; 0 for all other ops
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register
- Busy  out  1  iterative MD op in flight

## Operation
- ALU_Ctr encoding:
  - 0 add, 1 sub, 2 or
  - 3 lui: SrcB << (WIDTH/2)
  - 4 and, 5 xor, 6 nor
  - 7 slt (signed), 8 sltu: result is 1 or 0, zero-extended
  - 9 sll, 10 srl, 11 sra: SrcB shifted by Shamt
  - 12 sllv: SrcB << SrcA[SHW-1:0]
  - 13 mfhi: ALU_Result = HI
  - 14 mflo: ALU_Result = LO
  - 15: ALU_Result = 0
- Add/sub wrap modulo 2^WIDTH.
- Overflow is set when the operand signs imply a sign-flipped result: for add, both operands share a sign that differs from the result's; for sub, the operands differ in sign and the result's sign differs from SrcA's.
- MD FSM has two states, IDLE and RUN, with down-counter cnt (SHW+1 bits).
  - IDLE, Start=1, MD_Op 0–3: latch operands, convert signed operands to magnitudes and record result signs, set cnt=WIDTH-1, go to RUN.
  - IDLE, Start=1, MD_Op 4/5: HI (or LO) ← SrcA at that edge; stay IDLE; Busy stays 0.
  - IDLE, Start=1, MD_Op 6/7: no effect.
  - RUN: one radix-2 step per cycle. Multiply is shift-add over a 2·WIDTH accumulator. Divide is restoring shift-subtract.
  - RUN, cnt==0: apply sign fix-up, write {HI,LO}, go to IDLE.
- Start is ignored while Busy=1; the in-flight op is unaffected.
- Multiply results: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
- Divide results: LO = quotient (truncated toward zero), HI = remainder (sign follows dividend).
- Divide by zero (div or divu): LO = all ones, HI = dividend. Takes the full latency.
- Signed MIN / −1: LO = MIN, HI = 0.
- mfhi/mflo while Busy=1 return the old HI/LO; the stall unit is responsible for preventing such reads.

## Timing
- Reset (asynchronous, while reset_n=0): HI=0, LO=0, Busy=0, FSM=IDLE, cnt=0, operand registers cleared.
- Reset during RUN aborts the operation; no partial result is written.
- Outputs at reset: ALU_Result, Zero and Overflow follow the inputs combinationally; HI=LO=0 makes mfhi/mflo return 0.
- MD latency, with Start sampled at edge k:
  - Busy=1 from edge k to edge k+WIDTH, i.e. WIDTH cycles.
  - HI/LO update at edge k+WIDTH; Busy falls at the same edge.
- Back-to-back: a new Start may be sampled at edge k+WIDTH+1, the first edge at which Busy=0 is seen.
- mthi/mtlo: 1-cycle write, visible after edge k.
- Registers touched by the FSM: Busy, HI, LO, cnt, operand/accumulator registers. ALU outputs are purely combinational.

## Test plan
- ALU ops, WIDTH=32:
  - add 0x7FFFFFFF + 1 → ALU_Result 0x80000000, Overflow=1, Zero=0
  - sub 5 − 5 → 0, Zero=1, Overflow=0
  - lui SrcB=0x1234 → 0x12340000
  - sra 0x80000000 by 4 → 0xF8000000
  - sltu 1 vs 0xFFFFFFFF → 1
- Multiply:
  - mult −3 × 5 → Busy=1 for exactly 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1
  - multu 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE
- Divide:
  - div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF
  - divu 7 / 0 → LO=0xFFFFFFFF, HI=7
  - div 0x80000000 / −1 → LO=0x80000000, HI=0
- Handshake:
  - Start div mid-mult → ignored; the mult result is unchanged
  - Start issued in the first cycle Busy=0 → accepted
  - mthi 0xABCD → HI=0xABCD one cycle later, Busy never asserted
- Reset:
  - reset_n pulsed low at cycle 10 of a mult → Busy=0, HI=LO=0 immediately
  - Next mult after reset completes correctly
- Parameter sweep, WIDTH=16: mult −1 × −1 → HI=0x0000, LO=0x0001, Busy=1 for 16 cycles; lui 0x12 → 0x1200
